user_rom_arbiter: RTL
=====================

Name: user_rom_arbiter

Overview:
- Shares the single read port of the user ROM between two requesters: the core's OBI subordinate path and the edge-detect accelerator's ROM fetch interface.
- Sits in user_domain between the OBI demux output / accelerator and the ROM storage array.
- Default policy gives the core priority. A wait counter forces an accelerator grant when the accelerator has been starved for MaxAccelWait cycles.
- Returns read data to the winner one cycle after grant, with byte-lane extraction for the accelerator.

Parameters:
- RomWords, 64, number of 32-bit ROM words; word index width RomIdxW = clog2(RomWords).
- MaxAccelWait, 8, consecutive cycles accel_req_i may be refused before it is forced to win; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  1  core read request
- obi_addr_i  in  32  core byte address; bits [RomIdxW+1:2] select the word
- obi_gnt_o  out  1  core request accepted this cycle
- obi_rvalid_o  out  1  core read data valid
- obi_rdata_o  out  32  core read data
- accel_req_i  in  1  accelerator read request
- accel_addr_i  in  8  accelerator byte address
- accel_gnt_o  out  1  accelerator request accepted this cycle
- accel_valid_o  out  1  accelerator data valid
- accel_data_o  out  8  selected ROM byte
- rom_req_o  out  1  ROM read enable
- rom_idx_o  out  RomIdxW  ROM word index
- rom_rdata_i  in  32  ROM word; valid the cycle after rom_req_o
- stat_obi_cnt_o  out  16  core grants counted (feature)
- stat_accel_cnt_o  out  16  accel grants counted (feature)
- stat_force_cnt_o  out  16  forced accel grants (feature)

Behaviour:
- Reset values:
  - All outputs are 0.
  - wait_cnt = 0.
  - owner_q = NONE.
  - state = CORE_PRIO.
- Grant logic is combinational within a cycle. At most one of obi_gnt_o / accel_gnt_o is high per cycle. rom_req_o = obi_gnt_o | accel_gnt_o.
- rom_idx_o depends on the winner:
  - core wins: obi_addr_i[RomIdxW+1:2]
  - accel wins: accel_addr_i[RomIdxW+1:2]
  - Address bits above the ROM range are ignored, so indices wrap modulo RomWords.
- FSM states:
  - CORE_PRIO:
    - If obi_req_i is high, the core wins. In that cycle, if accel_req_i is also high, wait_cnt increments.
    - Otherwise, if accel_req_i is high, the accelerator wins and wait_cnt clears.
    - When an accel_req_i is refused and wait_cnt == MaxAccelWait-1 (i.e. the next increment would reach MaxAccelWait), the next state is ACCEL_FORCE.
  - ACCEL_FORCE:
    - The accelerator wins unconditionally if accel_req_i is high. obi_gnt_o stays 0. wait_cnt clears. Return to CORE_PRIO.
    - If accel_req_i has dropped, return to CORE_PRIO the same cycle with no forced grant, and arbitrate as CORE_PRIO in that cycle.
- wait_cnt clears whenever accel_req_i is low or the accelerator is granted. wait_cnt saturates and never wraps.
- Response path, fixed 1-cycle latency:
  - owner_q registers the winner of the grant cycle.
  - Next cycle, if owner_q == OBI: obi_rvalid_o = 1 and obi_rdata_o = rom_rdata_i.
  - If owner_q == ACCEL: accel_valid_o = 1 and accel_data_o = rom_rdata_i byte lane accel_lane_q, registered from accel_addr_i[1:0].
  - Data outputs are 0 when not valid.
- Back-to-back grants to alternating owners are legal every cycle. There is no response buffering and no stall input; responses are never lost.
- A requester must hold req and addr until it sees its gnt. The arbiter does not register requests.
- Reset mid-transaction:
  - Any pending response is dropped and owner_q returns to NONE.
  - No valid or rvalid is issued after reset release until a new grant occurs.
- With MaxAccelWait = 1, every refused accel request forces the accelerator to win the following cycle, giving strict alternation under contention.

Optional Feature:
- Macro: USER_ROM_ARB_STATS_EN.
- Defined:
  - Three 16-bit saturating counters: core grants, accel grants, forced grants (each forced grant also counts as an accel grant).
  - Counters clear on reset and drive the stat_* ports.
- Undefined:
  - No counter flops are instantiated and the stat_* ports are tied to 0.
  - Arbitration behaviour is identical in both cases.

Decomposition:
- user_pkg holds:
  - the typedef rom_owner_e {OWNER_NONE, OWNER_OBI, OWNER_ACCEL}
  - the typedef rom_arb_state_e {CORE_PRIO, ACCEL_FORCE}
  - the constant UserRomWords = 64
- Sub-module user_rom_arb_stats holds the three saturating counters. It is instantiated only under the macro.
- The top module keeps the FSM, wait counter, and response mux.

Test Plan:
- Core only: obi_req_i = 1, obi_addr_i = 0x0000_0010 -> same-cycle obi_gnt_o, rom_idx_o = 4; next cycle obi_rvalid_o = 1, obi_rdata_o = ROM[4].
- Accel only: accel_addr_i = 0x0B -> accel_gnt_o, rom_idx_o = 2; next cycle accel_valid_o = 1, accel_data_o = ROM[2][31:24].
- Continuous contention, MaxAccelWait = 8 -> 8 consecutive core grants, then 1 accel grant, and the pattern repeats; stat_force_cnt_o increments once per 9 cycles when the macro is on.
- Accel drops its request while in ACCEL_FORCE -> the core is granted in that same cycle, state returns to CORE_PRIO, and wait_cnt = 0.
- Alternating grants core, accel, core -> the rvalid/valid pulses alternate with the correct data and no overlap.
- rst_ni asserted the cycle after a core grant -> obi_rvalid_o stays 0 and all outputs are 0 during reset and after release.

Source files
------------

// File: rtl/user_pkg.sv
// user_pkg: shared types and constants for the user-domain ROM arbiter.
// The owner encoding tags whichever requester is waiting for ROM data in the
// next cycle. The state encoding is the arbiter's priority mode.
package user_pkg;

    localparam int unsigned UserRomWords = 64;

    localparam int unsigned UserStatW = 16;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_OBI   = 2'd1,
        OWNER_ACCEL = 2'd2
    } rom_owner_e;

    typedef enum logic [0:0] {
        CORE_PRIO   = 1'b0,
        ACCEL_FORCE = 1'b1
    } rom_arb_state_e;

endpackage

// File: rtl/user_rom_arb_stats.sv
// user_rom_arb_stats: grant statistics for the user ROM arbiter.
// Three 16-bit saturating counters for core grants, accelerator grants and
// forced accelerator grants. A forced grant also arrives on accel_gnt_i, so
// it is counted in both accel_cnt_o and force_cnt_o.
// The top instantiates this block only when USER_ROM_ARB_STATS_EN is defined.
module user_rom_arb_stats
    import user_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 obi_gnt_i,
    input  logic                 accel_gnt_i,
    input  logic                 force_gnt_i,
    output logic [UserStatW-1:0] obi_cnt_o,
    output logic [UserStatW-1:0] accel_cnt_o,
    output logic [UserStatW-1:0] force_cnt_o
);

    logic [UserStatW-1:0] obi_cnt_q, obi_cnt_d;
    logic [UserStatW-1:0] accel_cnt_q, accel_cnt_d;
    logic [UserStatW-1:0] force_cnt_q, force_cnt_d;

    // Increment that holds at all-ones instead of wrapping to zero.
    function automatic logic [UserStatW-1:0] sat_inc(input logic [UserStatW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next-count: each counter bumps on its grant strobe.
    always_comb begin
        obi_cnt_d   = obi_gnt_i   ? sat_inc(obi_cnt_q)   : obi_cnt_q;
        accel_cnt_d = accel_gnt_i ? sat_inc(accel_cnt_q) : accel_cnt_q;
        force_cnt_d = force_gnt_i ? sat_inc(force_cnt_q) : force_cnt_q;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obi_cnt_q   <= '0;
            accel_cnt_q <= '0;
            force_cnt_q <= '0;
        end else begin
            obi_cnt_q   <= obi_cnt_d;
            accel_cnt_q <= accel_cnt_d;
            force_cnt_q <= force_cnt_d;
        end
    end

    assign obi_cnt_o   = obi_cnt_q;
    assign accel_cnt_o = accel_cnt_q;
    assign force_cnt_o = force_cnt_q;

endmodule

// File: rtl/user_rom_arbiter.sv
// user_rom_arbiter: shares the user ROM read port between the core OBI path
// and the edge-detect accelerator.
// The core has priority. A starvation counter forces one accelerator grant
// after MaxAccelWait consecutive refusals. The winner is recorded, and the ROM
// word is returned to it one cycle later. The accelerator receives one byte
// lane of that word.
// Optional build macro: USER_ROM_ARB_STATS_EN enables the grant statistics
// counters on the stat_* ports. Otherwise those ports are tied to 0.
module user_rom_arbiter
    import user_pkg::*;
#(
    parameter  int unsigned RomWords     = UserRomWords,
    parameter  int unsigned MaxAccelWait = 8,
    localparam int unsigned RomIdxW      = $clog2(RomWords)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // core OBI read path
    input  logic               obi_req_i,
    input  logic [31:0]        obi_addr_i,
    output logic               obi_gnt_o,
    output logic               obi_rvalid_o,
    output logic [31:0]        obi_rdata_o,
    // accelerator fetch path
    input  logic               accel_req_i,
    input  logic [7:0]         accel_addr_i,
    output logic               accel_gnt_o,
    output logic               accel_valid_o,
    output logic [7:0]         accel_data_o,
    // ROM storage port
    output logic               rom_req_o,
    output logic [RomIdxW-1:0] rom_idx_o,
    input  logic [31:0]        rom_rdata_i,
    // grant statistics
    output logic [15:0]        stat_obi_cnt_o,
    output logic [15:0]        stat_accel_cnt_o,
    output logic [15:0]        stat_force_cnt_o
);

    // MaxAccelWait is at most 255, so 8 bits are enough for the wait count.
    localparam int unsigned       WaitW    = 8;
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(MaxAccelWait - 1);

    rom_arb_state_e      state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    rom_owner_e          owner_q, owner_d;
    logic [1:0]          lane_q, lane_d;

    logic                obi_gnt;
    logic                accel_gnt;
    logic                accel_refused;
    logic                resp_obi;
    logic                resp_accel;
    logic [RomIdxW-1:0]  obi_idx;
    logic [RomIdxW-1:0]  accel_idx;

    // Word index = byte address / 4. Bits above the ROM range are dropped, so
    // the index wraps modulo the ROM size.
    assign obi_idx   = RomIdxW'(obi_addr_i >> 2);
    assign accel_idx = RomIdxW'(accel_addr_i >> 2);

    // Arbitration for the current cycle. A pending forced slot is honoured
    // only while the accelerator still requests. Otherwise the core keeps
    // priority in the same cycle. Grants are held low while in reset.
    always_comb begin
        obi_gnt   = 1'b0;
        accel_gnt = 1'b0;
        if (rst_ni) begin
            if ((state_q == ACCEL_FORCE) && accel_req_i) begin
                accel_gnt = 1'b1;
            end else if (obi_req_i) begin
                obi_gnt = 1'b1;
            end else if (accel_req_i) begin
                accel_gnt = 1'b1;
            end
        end
        accel_refused = accel_req_i & ~accel_gnt;
    end

    // Starvation tracking. Each refusal counts up, with saturation. Any cycle
    // where the accelerator is idle or granted clears the count. The refusal
    // that would reach MaxAccelWait arms the forced slot for the next cycle.
    always_comb begin
        wait_d  = '0;
        state_d = CORE_PRIO;
        if (accel_refused) begin
            wait_d = (&wait_q) ? wait_q : wait_q + 1'b1;
            if (wait_q == WaitLast) begin
                state_d = ACCEL_FORCE;
            end
        end
    end

    // Record who owns next cycle's ROM data, and which byte the accelerator
    // asked for.
    always_comb begin
        owner_d = OWNER_NONE;
        if (obi_gnt) begin
            owner_d = OWNER_OBI;
        end else if (accel_gnt) begin
            owner_d = OWNER_ACCEL;
        end
        lane_d = accel_gnt ? accel_addr_i[1:0] : 2'b00;
    end

    // Arbiter state. Reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CORE_PRIO;
            wait_q  <= '0;
            owner_q <= OWNER_NONE;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            owner_q <= owner_d;
            lane_q  <= lane_d;
        end
    end

    // ROM request and index follow the winner. The index is zero when idle.
    always_comb begin
        rom_req_o = obi_gnt | accel_gnt;
        rom_idx_o = '0;
        if (obi_gnt) begin
            rom_idx_o = obi_idx;
        end else if (accel_gnt) begin
            rom_idx_o = accel_idx;
        end
    end

    assign obi_gnt_o   = obi_gnt;
    assign accel_gnt_o = accel_gnt;

    // Response mux. The ROM word goes to the recorded owner. Data outputs are
    // zero whenever their valid is low.
    always_comb begin
        resp_obi      = (owner_q == OWNER_OBI);
        resp_accel    = (owner_q == OWNER_ACCEL);
        obi_rvalid_o  = resp_obi;
        obi_rdata_o   = resp_obi ? rom_rdata_i : 32'h0;
        accel_valid_o = resp_accel;
        accel_data_o  = resp_accel ? rom_rdata_i[{lane_q, 3'b000} +: 8] : 8'h0;
    end

`ifdef USER_ROM_ARB_STATS_EN
    logic force_gnt;

    // A forced grant is an accelerator grant issued from the forced slot.
    assign force_gnt = (state_q == ACCEL_FORCE) & accel_gnt;

    user_rom_arb_stats u_stats (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .obi_gnt_i   (obi_gnt),
        .accel_gnt_i (accel_gnt),
        .force_gnt_i (force_gnt),
        .obi_cnt_o   (stat_obi_cnt_o),
        .accel_cnt_o (stat_accel_cnt_o),
        .force_cnt_o (stat_force_cnt_o)
    );
`else
    assign stat_obi_cnt_o   = 16'h0;
    assign stat_accel_cnt_o = 16'h0;
    assign stat_force_cnt_o = 16'h0;
`endif

endmodule
